// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: PWM config register bank plus a duty-cycle ramp engine.
// Define PWM_FADE_IRQ_EN to add the sticky irq output cleared by control bit3.
module pwm_fade_scheduler #(
  parameter int TICK_DIV = 256,
  parameter int TICK_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       ramp_busy,
  output logic       ramp_done
`ifdef PWM_FADE_IRQ_EN
  ,
  output logic       irq
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, STEP} state_t;
  localparam logic [TICK_W-1:0] DIV = TICK_W'(TICK_DIV);
  state_t state;
  logic [7:0] target, step, period, origin, step_eff, nxt;
  logic [8:0] sum, dif;
  logic [TICK_W-1:0] cnt, limit;
  logic loop, ctrl, start, stop, duty_wr;
  assign ctrl = wr_valid && wr_addr == 7'h08;
  assign start = ctrl && wr_data[0];
  assign stop = ctrl && wr_data[2];
  assign duty_wr = wr_valid && wr_addr == 7'h04;
  always_comb begin
    step_eff = step == 8'd0 ? 8'd1 : step;
    sum = {1'b0, pwm_duty_cycle} + {1'b0, step_eff};
    dif = {1'b0, pwm_duty_cycle} - {1'b0, step_eff};
    nxt = target > pwm_duty_cycle ? (sum > {1'b0, target} ? target : sum[7:0])
                                   : (dif[8] || dif[7:0] < target ? target : dif[7:0]);
    limit = (TICK_W'(period) + TICK_W'(1)) * DIV - TICK_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      en_reg_out_7_0 <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0 <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle <= '0;
      ramp_busy <= 1'b0;
      ramp_done <= 1'b0;
      target <= '0;
      step <= '0;
      period <= '0;
      origin <= '0;
      cnt <= '0;
      loop <= 1'b0;
    end else begin
      ramp_done <= 1'b0;
      if (duty_wr) begin
        pwm_duty_cycle <= wr_data;
        state <= IDLE;
        ramp_busy <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        ramp_busy <= 1'b0;
      end else if (start && state == IDLE && target == pwm_duty_cycle) begin
        ramp_done <= 1'b1;
      end else if (start) begin
        origin <= pwm_duty_cycle;
        loop <= wr_data[1];
        cnt <= '0;
        state <= WAIT;
        ramp_busy <= 1'b1;
      end else if (state == WAIT) begin
        if (cnt >= limit) state <= STEP;
        else cnt <= cnt + TICK_W'(1);
      end else if (state == STEP) begin
        pwm_duty_cycle <= nxt;
        ramp_done <= nxt == target;
        if (nxt == target && !loop) begin
          state <= IDLE;
          ramp_busy <= 1'b0;
        end else begin
          // the STEP cycle itself counts toward the next tick interval
          cnt <= TICK_W'(1);
          state <= WAIT;
          if (nxt == target) begin
            target <= origin;
            origin <= target;
          end
        end
      end
      if (wr_valid) begin
        case (wr_addr)
          7'h00: en_reg_out_7_0 <= wr_data;
          7'h01: en_reg_out_15_8 <= wr_data;
          7'h02: en_reg_pwm_7_0 <= wr_data;
          7'h03: en_reg_pwm_15_8 <= wr_data;
          7'h05: target <= wr_data;
          7'h06: step <= wr_data;
          7'h07: period <= wr_data;
          default: ;
        endcase
      end
    end
  end
`ifdef PWM_FADE_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) irq <= 1'b0;
    else irq <= ramp_done || (irq && !(ctrl && wr_data[3]));
  end
`endif
endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// tb_pwm_fade_scheduler: directed table and sequence checks for pwm_fade_scheduler.
module tb_pwm_fade_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic ramp_busy, ramp_done;
`ifdef PWM_FADE_IRQ_EN
  logic irq;
`endif
  int checks = 0, errors = 0;
  logic [41:0] outs;
  assign outs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
                 pwm_duty_cycle, ramp_busy, ramp_done};
  always #5 clk = ~clk;
  pwm_fade_scheduler #(.TICK_DIV(4), .TICK_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .ramp_busy(ramp_busy),
    .ramp_done(ramp_done)
`ifdef PWM_FADE_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  typedef struct {
    logic [6:0]  a;
    logic [7:0]  d;
    logic [39:0] exp;
  } vec_t;
  vec_t vecs[8];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk3(input string name, input logic [7:0] d, input logic b, input logic r);
    check({name, " duty"}, 64'(pwm_duty_cycle), 64'(d));
    check({name, " busy"}, 64'(ramp_busy), 64'(b));
    check({name, " done"}, 64'(ramp_done), 64'(r));
  endtask
  // called at a negedge; the write lands on the next posedge and returns at the following negedge
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    vecs[0] = '{7'h00, 8'hA5, 40'hA5_00_00_00_00};
    vecs[1] = '{7'h03, 8'h3C, 40'hA5_00_00_3C_00};
    vecs[2] = '{7'h04, 8'h80, 40'hA5_00_00_3C_80};
    vecs[3] = '{7'h09, 8'hFF, 40'hA5_00_00_3C_80};
    vecs[4] = '{7'h7F, 8'h11, 40'hA5_00_00_3C_80};
    vecs[5] = '{7'h01, 8'h5A, 40'hA5_5A_00_3C_80};
    vecs[6] = '{7'h02, 8'hC3, 40'hA5_5A_C3_3C_80};
    vecs[7] = '{7'h05, 8'h77, 40'hA5_5A_C3_3C_80};
    cyc(2);
    check("reset outs", 64'(outs), 64'(0));
`ifdef PWM_FADE_IRQ_EN
    check("reset irq", 64'(irq), 64'(0));
`endif
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].a, vecs[i].d);
      check($sformatf("regwr %0d", i), 64'(outs), 64'({vecs[i].exp, 2'b00}));
    end
    wr(7'h08, 8'h08);
    check("ctrl bit3 only", 64'(outs), 64'({40'hA5_5A_C3_3C_80, 2'b00}));
    // saturating up-ramp: 0x10 -> 0x20 by 6, period 1
    wr(7'h04, 8'h10); wr(7'h05, 8'h20); wr(7'h06, 8'h06); wr(7'h07, 8'h01);
    wr(7'h08, 8'h01);
    chk3("up n0", 8'h10, 1'b1, 1'b0);
    for (int n = 1; n <= 26; n++) begin
      cyc(1);
      chk3($sformatf("up n%0d", n), n < 9 ? 8'h10 : n < 17 ? 8'h16 : n < 25 ? 8'h1C : 8'h20,
           n < 25, n == 25);
    end
    // down-ramp with step 0 acting as 1
    wr(7'h04, 8'h05); wr(7'h05, 8'h02); wr(7'h06, 8'h00); wr(7'h07, 8'h00);
    wr(7'h08, 8'h01);
    for (int n = 1; n <= 14; n++) begin
      cyc(1);
      chk3($sformatf("down n%0d", n), n < 5 ? 8'h05 : n < 9 ? 8'h04 : n < 13 ? 8'h03 : 8'h02,
           n < 13, n == 13);
    end
    // loop mode, then STOP
    wr(7'h04, 8'h00); wr(7'h05, 8'h04); wr(7'h06, 8'h02);
    wr(7'h08, 8'h03);
    for (int n = 1; n <= 22; n++) begin
      cyc(1);
      chk3($sformatf("loop n%0d", n),
           n < 5 ? 8'h00 : n < 9 ? 8'h02 : n < 13 ? 8'h04 : n < 17 ? 8'h02 : n < 21 ? 8'h00 : 8'h02,
           1'b1, n == 9 || n == 17);
    end
    wr(7'h08, 8'h04);
    chk3("stop", 8'h02, 1'b0, 1'b0);
    cyc(8);
    chk3("stop hold", 8'h02, 1'b0, 1'b0);
    // SPI duty write landing on the STEP cycle
    wr(7'h04, 8'h10); wr(7'h05, 8'h20); wr(7'h06, 8'h01); wr(7'h07, 8'h00);
    wr(7'h08, 8'h01);
    cyc(4);
    chk3("coll pre", 8'h10, 1'b1, 1'b0);
    wr(7'h04, 8'h99);
    chk3("coll", 8'h99, 1'b0, 1'b0);
    cyc(1);
    chk3("coll +1", 8'h99, 1'b0, 1'b0);
    cyc(5);
    chk3("coll +6", 8'h99, 1'b0, 1'b0);
    // reset mid-WAIT
    wr(7'h08, 8'h01);
    cyc(2);
    check("rst pre busy", 64'(ramp_busy), 64'(1));
    rst_n = 1'b0;
    cyc(1);
    check("rst mid outs", 64'(outs), 64'(0));
    rst_n = 1'b1;
    cyc(6);
    check("rst after outs", 64'(outs), 64'(0));
`ifdef PWM_FADE_IRQ_EN
    wr(7'h04, 8'h40); wr(7'h05, 8'h40);
    wr(7'h08, 8'h01);
    chk3("irq eq", 8'h40, 1'b0, 1'b1);
    check("irq eq n0", 64'(irq), 64'(0));
    cyc(1);
    check("irq set", 64'(irq), 64'(1));
    check("irq done low", 64'(ramp_done), 64'(0));
    cyc(3);
    check("irq sticky", 64'(irq), 64'(1));
    wr(7'h08, 8'h08);
    check("irq clr", 64'(irq), 64'(0));
    wr(7'h08, 8'h01);
    wr(7'h08, 8'h08);
    check("irq set wins", 64'(irq), 64'(1));
    cyc(2);
    check("irq hold", 64'(irq), 64'(1));
    wr(7'h08, 8'h08);
    check("irq clr2", 64'(irq), 64'(0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
